// File: rtl/qk_partial_sum_acc.sv
// -----------------------------------------------------------------------------
// qk_partial_sum_acc
//
// Purpose:
//   Combines partial-product tiles (INT, FRAC1, FRAC2, ...) from the Q x K
//   systolic array. Rows arrive one per cycle. Each term is optionally
//   pre-shifted by FRAC_SHIFT and accumulated into a ROWS x DIM buffer. The
//   combined tile is then drained row by row.
//
// Handshake (valid/ready):
//   A beat transfers on a rising clk edge where valid && ready are both 1.
//   Valid must not depend on ready. The source holds its data stable until the
//   transfer. While flush=1 no beat transfers on either side.
//
// Configuration macro:
//   QK_PSUM_SAT_EN  defined   : outputs clamp to the 2*WIDTH signed range,
//                               and sat_flag reports clamping.
//                   undefined : outputs take the low 2*WIDTH bits, and
//                               sat_flag is tied to 0.
//
// Ports:
//   clk            in   clock, rising edge
//   _reset         in   asynchronous active-low reset
//   flush          in   synchronous abort of the current tile
//   in_valid       in   input row valid
//   in_ready       out  input row accepted (high in FILL)
//   in_row         in   DIM signed 2*WIDTH partial products, element j at
//                       [j*2*WIDTH +: 2*WIDTH]
//   in_shift       in   1 = shift term left by FRAC_SHIFT before adding
//   in_last        in   final term of the tile (sampled on row ROWS-1)
//   out_valid      out  output row valid (high in DRAIN)
//   out_ready      in   output row consumed
//   out_row        out  DIM combined signed results, same packing as in_row
//   sat_flag       out  sticky saturation flag for the current output tile
//   o_dbg_state    out  FSM state (0 = FILL, 1 = DRAIN)
//   o_dbg_row_cnt  out  current fill row index
// -----------------------------------------------------------------------------
module qk_partial_sum_acc #(
    parameter int WIDTH      = 8,
    parameter int DIM        = 4,
    parameter int ROWS       = 4,
    parameter int FRAC_SHIFT = 8,
    parameter int GUARD      = 4,
    localparam int CNT_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                     clk,
    input  logic                     _reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DIM*2*WIDTH-1:0]   in_row,
    input  logic                     in_shift,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DIM*2*WIDTH-1:0]   out_row,
    output logic                     sat_flag,
    output logic                     o_dbg_state,
    output logic [CNT_W-1:0]         o_dbg_row_cnt
);

    localparam int EW    = 2 * WIDTH;
    localparam int ACC_W = EW + GUARD;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_row_cnt;
    logic [CNT_W-1:0]        r_drain_cnt;
    logic                    r_first_term;
    logic [ACC_W-1:0]        r_buf [ROWS][DIM];

    logic                    w_accept;
    logic                    w_drain_hs;
    logic                    w_last_row;
    logic                    w_last_drain;
    logic                    w_tile_done;
    logic [DIM-1:0][ACC_W-1:0] w_term;
    logic [DIM-1:0][EW-1:0]  w_conv;

    // -------------------------------------------------------------------------
    // Handshake qualifiers. flush outranks both sides.
    // -------------------------------------------------------------------------
    assign in_ready     = (r_state == S_FILL);
    assign out_valid    = (r_state == S_DRAIN);
    assign w_accept     = in_valid && in_ready && !flush;
    assign w_drain_hs   = out_valid && out_ready && !flush;
    assign w_last_row   = (r_row_cnt == CNT_W'(ROWS - 1));
    assign w_last_drain = (r_drain_cnt == CNT_W'(ROWS - 1));
    // Last row of the last term accepted: the tile is complete.
    assign w_tile_done  = w_accept && w_last_row && in_last;

    assign o_dbg_state   = r_state;
    assign o_dbg_row_cnt = r_row_cnt;

    // -------------------------------------------------------------------------
    // Term conditioning: sign-extend to ACC_W, then optionally scale.
    // -------------------------------------------------------------------------
    for (genvar j = 0; j < DIM; j++) begin : g_term
        logic [ACC_W-1:0] w_ext;
        assign w_ext     = ACC_W'($signed(in_row[j*EW +: EW]));
        assign w_term[j] = in_shift ? (w_ext << FRAC_SHIFT) : w_ext;
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_FILL;
        end else begin
            case (r_state)
                S_FILL:  if (w_tile_done) w_state_nxt = S_DRAIN;
                S_DRAIN: if (w_drain_hs && w_last_drain) w_state_nxt = S_FILL;
                default: w_state_nxt = S_FILL;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Counters and accumulator buffer.
    // flush leaves the buffer alone. first_term=1 makes the next term
    // overwrite it, so stale contents never leak into a new tile.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_row_cnt    <= '0;
            r_drain_cnt  <= '0;
            r_first_term <= 1'b1;
            for (int r = 0; r < ROWS; r++) begin
                for (int j = 0; j < DIM; j++) begin
                    r_buf[r][j] <= '0;
                end
            end
        end else if (flush) begin
            r_row_cnt    <= '0;
            r_drain_cnt  <= '0;
            r_first_term <= 1'b1;
        end else begin
            if (w_accept) begin
                for (int j = 0; j < DIM; j++) begin
                    if (r_first_term) begin
                        r_buf[r_row_cnt][j] <= w_term[j];
                    end else begin
                        r_buf[r_row_cnt][j] <= r_buf[r_row_cnt][j] + w_term[j];
                    end
                end
                r_row_cnt <= w_last_row ? '0 : r_row_cnt + CNT_W'(1);
                if (w_last_row) begin
                    if (in_last) begin
                        r_drain_cnt <= '0;
                    end else begin
                        r_first_term <= 1'b0;
                    end
                end
            end
            if (w_drain_hs) begin
                r_drain_cnt <= w_last_drain ? '0 : r_drain_cnt + CNT_W'(1);
                if (w_last_drain) begin
                    r_first_term <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output conversion from the registered buffer row selected by drain_cnt.
    // -------------------------------------------------------------------------
`ifdef QK_PSUM_SAT_EN
    logic [DIM-1:0] w_elem_sat;
    logic           w_row_sat;
    logic           r_sat_flag;

    for (genvar j = 0; j < DIM; j++) begin : g_conv
        logic [ACC_W-1:0] w_sel;
        logic [GUARD:0]   w_hi;
        logic             w_pos_ovf;
        logic             w_neg_ovf;
        assign w_sel = r_buf[r_drain_cnt][j];
        // The value fits in EW signed bits only if every bit from the EW sign
        // bit upward equals the ACC_W sign bit.
        assign w_hi      = w_sel[ACC_W-1:EW-1];
        assign w_pos_ovf = !w_sel[ACC_W-1] && (|w_hi);
        assign w_neg_ovf =  w_sel[ACC_W-1] && !(&w_hi);
        assign w_elem_sat[j] = w_pos_ovf || w_neg_ovf;
        assign w_conv[j] = w_pos_ovf ? {1'b0, {(EW-1){1'b1}}} :
                           w_neg_ovf ? {1'b1, {(EW-1){1'b0}}} :
                                       w_sel[EW-1:0];
    end

    assign w_row_sat = |w_elem_sat;

    // Cleared when a tile enters DRAIN; set by any drained row that clamped.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_sat_flag <= 1'b0;
        end else if (w_tile_done) begin
            r_sat_flag <= 1'b0;
        end else if (w_drain_hs && w_row_sat) begin
            r_sat_flag <= 1'b1;
        end
    end

    assign sat_flag = r_sat_flag;
`else
    for (genvar j = 0; j < DIM; j++) begin : g_conv
        assign w_conv[j] = r_buf[r_drain_cnt][j][EW-1:0];
    end

    assign sat_flag = 1'b0;
`endif

    // out_row reads zero outside DRAIN, so the reset value and the idle value match.
    for (genvar j = 0; j < DIM; j++) begin : g_out
        assign out_row[j*EW +: EW] = (r_state == S_DRAIN) ? w_conv[j] : '0;
    end

endmodule

// File: doc/qk_partial_sum_acc.md
# qk_partial_sum_acc

Parametrised partial-product combiner for the Q×K systolic array. It accepts an arbitrary number of partial-product tiles (INT, FRAC1, FRAC2 and future terms) as a row-per-cycle stream. Each term is optionally pre-shifted by the fraction width and added into a ROWS×DIM accumulator buffer. The combined tile is then drained row by row through a valid/ready handshake. It sits between the systolic array outputs and the softmax/scaling stage, and replaces the fixed 4×4, two-operand adder.

## Interface
- WIDTH, 8: operand width; partial products and results are 2*WIDTH signed.
- DIM, 4: elements per row.
- ROWS, 4: rows per tile.
- FRAC_SHIFT, 8: left shift applied to terms tagged integer.
- GUARD, 4: accumulator guard bits; ACC_W = 2*WIDTH+GUARD.

Ports:
- clk  in  1  clock, rising edge.
- _reset  in  1  reset _reset, asynchronous, active-low; clock clk.
- flush  in  1  synchronous abort of the current tile.
- in_valid  in  1  input row valid.
- in_ready  out  1  input row accepted when in_valid&&in_ready.
- in_row  in  DIM*2*WIDTH  signed partial products; element j at [j*2*WIDTH +: 2*WIDTH].
- in_shift  in  1  1 = integer-scaled term (shift by FRAC_SHIFT), 0 = add as-is.
- in_last  in  1  this term is the final term of the tile; sampled only on row ROWS-1.
- out_valid  out  1  output row valid.
- out_ready  in  1  output row consumed when out_valid&&out_ready.
- out_row  out  DIM*2*WIDTH  combined signed results, same packing as in_row.
- sat_flag  out  1  sticky: some element of the current output tile saturated.

## Operation
- States: FILL, DRAIN. Reset state is FILL, with row_cnt=0, drain_cnt=0, first_term=1, the buffer cleared to 0, and sat_flag=0.
- in_ready = (state==FILL). out_valid = (state==DRAIN).
- FILL, on each accepted row r = row_cnt:
  - Each element is sign-extended to ACC_W.
  - If in_shift=1, the element is arithmetically shifted left by FRAC_SHIFT.
  - If first_term=1, buf[r][j] is overwritten with the result; otherwise buf[r][j] += result (ACC_W wrap).
  - row_cnt increments and wraps ROWS-1→0.
- Accept at row ROWS-1:
  - If in_last=0: first_term←0.
  - If in_last=1: go to DRAIN, drain_cnt←0, sat_flag←0.
- DRAIN:
  - out_row = conv(buf[drain_cnt]), driven from registered state only and stable while out_ready=0.
  - On a handshake, drain_cnt increments. On the handshake at drain_cnt=ROWS-1, go to FILL with first_term=1.
  - sat_flag is set in the cycle after any drained row contains a saturated element. It holds until the next tile enters DRAIN.
- A single-term tile is legal (in_last=1 on the first term). Term count is unbounded.
- Overflow beyond the GUARD bits wraps silently.
- flush=1 has priority over all handshakes:
  - state←FILL, row_cnt←0, drain_cnt←0, first_term←1.
  - The buffer is not cleared; the next term overwrites it.
  - No row is accepted or emitted in the flush cycle.
- Asynchronous reset mid-tile discards all content; outputs take their reset values immediately.

## Timing
- Reset values: in_ready=1, out_valid=0, out_row=0, sat_flag=0.
- Input throughput is 1 row/cycle in FILL.
- out_valid rises the cycle after the last row of the last term is accepted, so fill-to-first-output latency is 1 cycle.
- Drain runs at 1 row/cycle with out_ready held high. Back-to-back tiles therefore cost ROWS×terms + ROWS cycles.
- in_ready rises the cycle after the final drain handshake; there is no overlap of FILL and DRAIN.
- in_valid with in_ready=0 is ignored; the source holds the row.

## Configuration
- QK_PSUM_SAT_EN defined:
  - conv() clamps each ACC_W value to [-2^(2*WIDTH-1), 2^(2*WIDTH-1)-1].
  - sat_flag behaves as above.
- QK_PSUM_SAT_EN undefined:
  - conv() takes the low 2*WIDTH bits (two's-complement wrap).
  - sat_flag is tied to 0, and the saturation logic is absent.

## Test plan
- 2 terms, all elements 3 (shift=1) then 5 (shift=0, last) → every out element 773, 4 rows, out_valid 1 cycle after the last input.
- 3 terms: 1 (shift=1), 128 (shift=0), 128 (shift=0, last) → all 512. Then an immediate second tile, single term 7 (shift=1, last) → all 1792, proving first-term overwrite.
- Signed: -2 (shift=1) plus 100 (shift=0, last) → -412 in all elements.
- Saturation: 200 (shift=1, last):
  - with QK_PSUM_SAT_EN → 32767, sat_flag=1;
  - without → -14336, sat_flag=0.
- Backpressure: out_ready low 3 cycles at drain row 1 → out_row stable, in_ready=0 and the input stalls, then rows 1–3 drain in order.
- flush during term-2 row 2 → in_ready=1 next cycle and row_cnt=0. A fresh term 4 (shift=0, last) → all 4. Async reset mid-DRAIN → out_valid=0 immediately.
